// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain: in-order pipeline register chain carrying a control/data
// bundle through DEPTH stages, between decode and write-back.
// Each stage can be stalled or flushed on its own. Back-pressure ripples toward
// stage 0 only through valid stages, so bubbles collapse instead of blocking.
// The retired output counts items handed off by the oldest stage and
// saturates at all-ones instead of wrapping.
module ctrl_pipe_chain #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   R,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  output logic [DEPTH-1:0]       stg_valid,
  output logic [DEPTH*WIDTH-1:0] stg_data,
  output logic                   retire,
  output logic [CNT_W-1:0]       retired
);

  // Stage registers: index 0 is the youngest stage, DEPTH-1 is the oldest.
  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] data_p [DEPTH];

  // Per-stage hold, plus the view each stage has of the stage feeding it.
  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] up_vld;
  logic [DEPTH-1:0] up_hold;
  logic [WIDTH-1:0] up_data [DEPTH];

  // Add one to the retired counter, but stop at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Back-pressure chain from the oldest stage down; a running term avoids self-reference.
  always_comb begin
    logic h;
    hold = '0;
    h = stall[DEPTH-1];
    hold[DEPTH-1] = h;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      h = stall[i] | (h & vld_p[i]);
      hold[i] = h;
    end
  end

  // Source of each stage: the input port for stage 0, the previous stage otherwise.
  always_comb begin
    up_vld     = '0;
    up_hold    = '0;
    up_data[0] = in_valid ? in_data : NOP_VALUE;
    up_vld[0]  = in_valid;
    for (int i = 1; i < DEPTH; i++) begin
      up_vld[i]  = vld_p[i-1];
      up_hold[i] = hold[i-1];
      up_data[i] = data_p[i-1];
    end
  end

  assign in_ready = ~hold[0] & ~flush[0];
  assign retire   = vld_p[DEPTH-1] & ~hold[DEPTH-1] & ~flush[DEPTH-1];

  // Stage update, priority: flush, hold, bubble behind a held stage, then load.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) data_p[i] <= NOP_VALUE;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (flush[i]) begin
          vld_p[i]  <= 1'b0;
          data_p[i] <= NOP_VALUE;
        end else if (hold[i]) begin
          vld_p[i]  <= vld_p[i];
          data_p[i] <= data_p[i];
        end else if (up_hold[i]) begin
          vld_p[i]  <= 1'b0;
          data_p[i] <= NOP_VALUE;
        end else begin
          vld_p[i]  <= up_vld[i];
          data_p[i] <= up_data[i];
        end
      end
    end
  end

  // Retired-item counter, bumped on every edge where the oldest stage hands off.
  always_ff @(posedge clk or negedge R) begin
    if (!R) retired <= '0;
    else if (retire) retired <= sat_inc(retired);
  end

  // Flatten the stage registers onto the output buses.
  always_comb begin
    stg_data  = '0;
    stg_valid = vld_p;
    for (int i = 0; i < DEPTH; i++) stg_data[i*WIDTH +: WIDTH] = data_p[i];
  end

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Testbench for ctrl_pipe_chain: directed scenarios with a retire-order scoreboard.
module tb_ctrl_pipe_chain;
  localparam int          WIDTH = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_00EE;

  logic        clk = 1'b0;
  logic        R = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  stall = '0;
  logic [3:0]  flush = '0;
  logic        in_ready, retire;
  logic [3:0]  stg_valid;
  logic [127:0] stg_data;
  logic [15:0] retired;
  logic        in_ready2, retire2;
  logic [3:0]  stg_valid2;
  logic [127:0] stg_data2;
  logic [1:0]  retired2;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  ctrl_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP_VALUE(NOP), .CNT_W(16)) dut (
    .clk(clk), .R(R), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall(stall), .flush(flush), .stg_valid(stg_valid), .stg_data(stg_data),
    .retire(retire), .retired(retired));

  ctrl_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NOP_VALUE(NOP), .CNT_W(2)) dut_sat (
    .clk(clk), .R(R), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2),
    .stall(stall), .flush(flush), .stg_valid(stg_valid2), .stg_data(stg_data2),
    .retire(retire2), .retired(retired2));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t required < 100000", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] stg(input int i);
    return stg_data[i*32 +: 32];
  endfunction

  task automatic drive(input bit v, input logic [31:0] d, input logic [3:0] st, input logic [3:0] fl);
    in_valid = v;
    in_data  = d;
    stall    = st;
    flush    = fl;
  endtask

  // One clock: check in_ready, push accepted item, pop/compare on retire, end at next negedge.
  task automatic cycle(input bit exp_rdy);
    logic [31:0] e;
    #1;
    checks++;
    if (in_ready !== exp_rdy) begin
      errors++;
      $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
    end
    if (in_valid && exp_rdy) sb.push_back(in_data);
    if (retire === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL retire_unexpected: got retire of %h expected no retire at %0t", stg(3), $time);
      end else begin
        e = sb.pop_front();
        if (stg(3) !== e) begin
          errors++;
          $display("FAIL retire_data: got %h expected %h at %0t", stg(3), e, $time);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    drive(1'b0, '0, '0, '0);
    repeat (DEPTH) cycle(1'b1);
    checks++;
    if (sb.size() != 0 || stg_valid !== 4'b0000) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending, valid %b expected 0 pending, valid 0000", name, sb.size(), stg_valid);
    end
  endtask

  task automatic fill(input logic [31:0] base);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, base + 32'(k), '0, '0);
      cycle(1'b1);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (stg_valid !== 4'b0000 || stg_data !== {4{NOP}} || retired !== 16'd0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid %b data %h retired %0d retire %b expected 0000 %h 0 0",
               stg_valid, stg_data, retired, retire, {4{NOP}});
    end
    @(negedge clk);
    R = 1'b1;
  endtask

  task automatic test_fill();
    fill(32'hA1);
    checks++;
    if (stg_valid !== 4'b1111 || stg(3) !== 32'hA1 || stg(0) !== 32'hA4) begin
      errors++;
      $display("FAIL fill_latency: got valid %b s3 %h s0 %h expected 1111 a1 a4", stg_valid, stg(3), stg(0));
    end
    drain("fill");
    checks++;
    if (retired !== 16'd4) begin
      errors++;
      $display("FAIL fill_retired: got %0d expected 4", retired);
    end
  endtask

  task automatic test_stall();
    fill(32'hB1);
    drive(1'b1, 32'hB5, 4'b0100, '0);
    cycle(1'b0);
    checks++;
    if (stg_valid !== 4'b0111 || stg(3) !== NOP || stg(2) !== 32'hB2 || stg(1) !== 32'hB3 || stg(0) !== 32'hB4) begin
      errors++;
      $display("FAIL stall_first: got valid %b data %h expected 0111 %h", stg_valid, stg_data,
               {NOP, 32'hB2, 32'hB3, 32'hB4});
    end
    cycle(1'b0);
    checks++;
    if (stg_valid !== 4'b0111 || stg(3) !== NOP || stg(0) !== 32'hB4) begin
      errors++;
      $display("FAIL stall_second: got valid %b s3 %h s0 %h expected 0111 %h b4", stg_valid, stg(3), stg(0), NOP);
    end
    drive(1'b1, 32'hB5, '0, '0);
    cycle(1'b1);
    checks++;
    if (stg_valid !== 4'b1111 || stg(3) !== 32'hB2 || stg(0) !== 32'hB5) begin
      errors++;
      $display("FAIL stall_release: got valid %b s3 %h s0 %h expected 1111 b2 b5", stg_valid, stg(3), stg(0));
    end
    drain("stall");
    checks++;
    if (retired !== 16'd9) begin
      errors++;
      $display("FAIL stall_retired: got %0d expected 9", retired);
    end
  endtask

  task automatic test_collapse();
    drive(1'b1, 32'hC1, '0, '0); cycle(1'b1);
    drive(1'b0, '0, '0, '0);     cycle(1'b1);
    drive(1'b1, 32'hC2, '0, '0); cycle(1'b1);
    checks++;
    if (stg_valid !== 4'b0101) begin
      errors++;
      $display("FAIL collapse_setup: got valid %b expected 0101", stg_valid);
    end
    drive(1'b1, 32'hC3, 4'b1000, '0);
    cycle(1'b1);
    checks++;
    if (stg_valid !== 4'b0111 || stg(2) !== 32'hC1 || stg(1) !== 32'hC2 || stg(0) !== 32'hC3) begin
      errors++;
      $display("FAIL collapse_advance: got valid %b s2 %h s1 %h s0 %h expected 0111 c1 c2 c3",
               stg_valid, stg(2), stg(1), stg(0));
    end
    drive(1'b1, 32'hC4, 4'b1000, '0);
    cycle(1'b0);
    checks++;
    if (stg_valid !== 4'b0111 || stg(0) !== 32'hC3) begin
      errors++;
      $display("FAIL collapse_blocked: got valid %b s0 %h expected 0111 c3", stg_valid, stg(0));
    end
    drain("collapse");
  endtask

  task automatic test_flush();
    fill(32'hD1);
    drive(1'b1, 32'hD5, '0, 4'b0011);
    cycle(1'b0);
    void'(sb.pop_back());
    checks++;
    if (stg_valid !== 4'b1100 || stg(3) !== 32'hD2 || stg(2) !== 32'hD3 || stg(1) !== NOP || stg(0) !== NOP) begin
      errors++;
      $display("FAIL flush_state: got valid %b data %h expected 1100 %h", stg_valid, stg_data,
               {32'hD2, 32'hD3, NOP, NOP});
    end
    drain("flush");
    checks++;
    if (retired !== 16'd15) begin
      errors++;
      $display("FAIL flush_retired: got %0d expected 15", retired);
    end
  endtask

  task automatic test_stall_flush();
    fill(32'h51);
    drive(1'b1, 32'h55, 4'b0100, 4'b0100);
    cycle(1'b0);
    void'(sb.pop_front());
    checks++;
    if (stg_valid !== 4'b0011 || stg(3) !== NOP || stg(2) !== NOP || stg(1) !== 32'h53 || stg(0) !== 32'h54) begin
      errors++;
      $display("FAIL stall_flush_state: got valid %b data %h expected 0011 %h", stg_valid, stg_data,
               {NOP, NOP, 32'h53, 32'h54});
    end
    drain("stall_flush");
    checks++;
    if (retired !== 16'd18) begin
      errors++;
      $display("FAIL stall_flush_retired: got %0d expected 18", retired);
    end
  endtask

  task automatic test_async_reset();
    fill(32'h61);
    drive(1'b0, '0, '0, '0);
    #2;
    R = 1'b0;
    #1;
    checks++;
    if (stg_valid !== 4'b0000 || stg_data !== {4{NOP}} || retired !== 16'd0 || retire !== 1'b0 || retired2 !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: got valid %b data %h retired %0d retire %b expected 0000 %h 0 0",
               stg_valid, stg_data, retired, retire, {4{NOP}});
    end
    sb.delete();
    @(negedge clk);
    R = 1'b1;
    drive(1'b1, 32'hF1, '0, '0);
    cycle(1'b1);
    checks++;
    if (stg_valid !== 4'b0001 || stg(0) !== 32'hF1) begin
      errors++;
      $display("FAIL reset_release: got valid %b s0 %h expected 0001 f1", stg_valid, stg(0));
    end
    drain("async_reset");
  endtask

  task automatic test_saturate();
    logic [1:0] tab [5];
    bit r;
    int idx;
    tab = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    idx = 0;
    #2;
    R = 1'b0;
    #1;
    sb.delete();
    @(negedge clk);
    R = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k < 5) drive(1'b1, 32'hE1 + 32'(k), '0, '0);
      else drive(1'b0, '0, '0, '0);
      #1;
      r = retire;
      cycle(1'b1);
      if (r && idx < 5) begin
        checks++;
        if (retired2 !== tab[idx] || retired !== 16'(idx + 1)) begin
          errors++;
          $display("FAIL saturate_%0d: got narrow %0d wide %0d expected %0d %0d", idx, retired2, retired,
                   tab[idx], idx + 1);
        end
        idx++;
      end
    end
    checks++;
    if (idx != 5 || sb.size() != 0) begin
      errors++;
      $display("FAIL saturate_count: got %0d retires, %0d pending expected 5 retires, 0 pending", idx, sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_collapse();
    test_flush();
    test_stall_flush();
    test_async_reset();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
